frame_stream_packer: RTL and testbench

- Store-and-forward transmit-side framer: accepts one raw Ethernet frame on an AXI4-Stream slave and emits it on an AXI4-Stream master as [frame length header][payload][timestamp footer], each part optional.
- Sits upstream of any consumer expecting length-prefixed, timestamp-suffixed frames. It is the producer for the existing frame-length/timestamp checker format.
- Holds one frame at a time.

---
 rtl/frame_stream_packer_if.sv | 14 +
 rtl/frame_stream_packer.sv | 232 +++++++++++++++++++++++
 tb/tb_frame_stream_packer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_stream_packer_if.sv
// AXI4-Stream bundle used on both sides of the frame packer.
// The master modport drives data, valid and last and receives ready.
// The slave modport is the receiving side of the same bundle.
interface frame_stream_packer_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/frame_stream_packer.sv
// Store-and-forward transmit framer.
// It buffers one ingress frame, then emits an optional length header, the
// payload, and an optional timestamp footer. Header and footer go out
// least-significant beat first. All egress signals come straight from flops.
module frame_stream_packer #(
    parameter int DATA_WIDTH                 = 8,
    parameter int MAX_FRAME_BEATS            = 1600,
    parameter int ENABLE_FRAME_LENGTH_HEADER = 1,
    parameter int ENABLE_TIMESTAMP_FOOTER    = 1,
    parameter int FRAME_LENGTH_WIDTH         = 16,
    parameter int TIMESTAMP_WIDTH            = 72
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
    frame_stream_packer_if.slave       s_axis,
    frame_stream_packer_if.master      m_axis,
    output logic                       frame_dropped
);
    localparam int LEN_BEATS = FRAME_LENGTH_WIDTH / DATA_WIDTH;
    localparam int TS_BEATS  = TIMESTAMP_WIDTH / DATA_WIDTH;
    localparam int CNT_W     = $clog2(MAX_FRAME_BEATS + 1);
    localparam int MAX_SECT  = (MAX_FRAME_BEATS > LEN_BEATS)
                             ? ((MAX_FRAME_BEATS > TS_BEATS) ? MAX_FRAME_BEATS : TS_BEATS)
                             : ((LEN_BEATS > TS_BEATS) ? LEN_BEATS : TS_BEATS);
    localparam int BEAT_W    = $clog2(MAX_SECT + 1);
    localparam bit HDR_EN    = (ENABLE_FRAME_LENGTH_HEADER != 0);
    localparam bit FTR_EN    = (ENABLE_TIMESTAMP_FOOTER != 0);

    typedef enum logic [2:0] {
        RECV      = 3'd0,
        DROP      = 3'd1,
        SEND_LEN  = 3'd2,
        SEND_DATA = 3'd3,
        SEND_TS   = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]           frame_len_q, frame_len_d;
    logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [TIMESTAMP_WIDTH-1:0] ts_q, ts_d;
    logic                       done_q, done_d;
    logic                       s_ready_q, s_ready_d;
    logic                       m_valid_q, m_valid_d;
    logic                       m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0]      m_data_q, m_data_d;
    logic                       dropped_q, dropped_d;

    logic [DATA_WIDTH-1:0]         buf_mem [MAX_FRAME_BEATS];
    logic                          buf_we_s;
    logic                          s_fire_s;
    logic                          m_fire_s;
    logic                          load_s;
    logic                          last_data_s;
    logic [CNT_W-1:0]              rd_idx_s;
    logic [FRAME_LENGTH_WIDTH-1:0] len_ext_s;

    assign s_fire_s    = s_axis.tvalid && s_ready_q;
    assign m_fire_s    = m_valid_q && m_axis.tready;
    // The output register may take a new beat when it is empty or being drained.
    assign load_s      = !m_valid_q || m_axis.tready;
    assign rd_idx_s    = CNT_W'(beat_cnt_q);
    assign last_data_s = (BEAT_W'(frame_len_q) == (beat_cnt_q + BEAT_W'(1)));
    // Oversized lengths wrap into the header width on purpose.
    assign len_ext_s   = FRAME_LENGTH_WIDTH'(frame_len_q);

    // Next-state, counter and egress-beat selection for the framer FSM.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        frame_len_d = frame_len_q;
        beat_cnt_d  = beat_cnt_q;
        ts_d        = ts_q;
        done_d      = done_q;
        s_ready_d   = s_ready_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        dropped_d   = 1'b0;
        buf_we_s    = 1'b0;
        case (state_q)
            RECV: begin
                s_ready_d = 1'b1;
                if (s_fire_s) begin
                    buf_we_s = 1'b1;
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_q == '0) begin
                        ts_d = timestamp;
                    end else begin
                        ts_d = ts_q;
                    end
                    if (s_axis.tlast) begin
                        frame_len_d = wr_cnt_q + CNT_W'(1);
                        wr_cnt_d    = '0;
                        beat_cnt_d  = '0;
                        done_d      = 1'b0;
                        s_ready_d   = 1'b0;
                        state_d     = HDR_EN ? SEND_LEN : SEND_DATA;
                    end else if (wr_cnt_q == CNT_W'(MAX_FRAME_BEATS - 1)) begin
                        state_d = DROP;
                    end else begin
                        state_d = RECV;
                    end
                end else begin
                    buf_we_s = 1'b0;
                end
            end
            DROP: begin
                s_ready_d = 1'b1;
                if (s_fire_s && s_axis.tlast) begin
                    dropped_d = 1'b1;
                    wr_cnt_d  = '0;
                    state_d   = RECV;
                end else begin
                    state_d = DROP;
                end
            end
            SEND_LEN, SEND_DATA, SEND_TS: begin
                s_ready_d = 1'b0;
                if (done_q) begin
                    // Every beat is loaded; wait for the tlast beat to leave.
                    if (m_fire_s) begin
                        state_d     = RECV;
                        s_ready_d   = 1'b1;
                        done_d      = 1'b0;
                        beat_cnt_d  = '0;
                        frame_len_d = '0;
                        m_valid_d   = 1'b0;
                        m_last_d    = 1'b0;
                    end else begin
                        m_valid_d = m_valid_q;
                    end
                end else if (load_s) begin
                    m_valid_d = 1'b1;
                    case (state_q)
                        SEND_LEN: begin
                            m_data_d = len_ext_s[int'(beat_cnt_q) * DATA_WIDTH +: DATA_WIDTH];
                            m_last_d = 1'b0;
                            if (beat_cnt_q == BEAT_W'(LEN_BEATS - 1)) begin
                                beat_cnt_d = '0;
                                state_d    = SEND_DATA;
                            end else begin
                                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                            end
                        end
                        SEND_DATA: begin
                            m_data_d = buf_mem[rd_idx_s];
                            if (last_data_s) begin
                                beat_cnt_d = '0;
                                if (FTR_EN) begin
                                    m_last_d = 1'b0;
                                    state_d  = SEND_TS;
                                end else begin
                                    m_last_d = 1'b1;
                                    done_d   = 1'b1;
                                end
                            end else begin
                                m_last_d   = 1'b0;
                                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                            end
                        end
                        SEND_TS: begin
                            m_data_d = ts_q[int'(beat_cnt_q) * DATA_WIDTH +: DATA_WIDTH];
                            if (beat_cnt_q == BEAT_W'(TS_BEATS - 1)) begin
                                m_last_d   = 1'b1;
                                done_d     = 1'b1;
                                beat_cnt_d = '0;
                            end else begin
                                m_last_d   = 1'b0;
                                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                            end
                        end
                        default: begin
                            m_valid_d = 1'b0;
                        end
                    endcase
                end else begin
                    m_valid_d = m_valid_q;
                end
            end
            default: begin
                state_d   = RECV;
                s_ready_d = 1'b0;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        endcase
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RECV;
            wr_cnt_q    <= '0;
            frame_len_q <= '0;
            beat_cnt_q  <= '0;
            ts_q        <= '0;
            done_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            frame_len_q <= frame_len_d;
            beat_cnt_q  <= beat_cnt_d;
            ts_q        <= ts_d;
            done_q      <= done_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
            dropped_q   <= dropped_d;
        end
    end

    // Payload buffer write port; the contents need no reset.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_mem[wr_cnt_q] <= s_axis.tdata;
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tlast  = m_last_q;
    assign frame_dropped = dropped_q;
endmodule

// File: tb/tb_frame_stream_packer.sv
// Bench for frame_stream_packer: a default-configured instance plus one with
// header and footer disabled, compared against a queue-based packed-frame model.
module tb_frame_stream_packer;
    localparam int DW   = 8;
    localparam int MAXB = 1600;
    localparam int FLW  = 16;
    localparam int TSW  = 72;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [TSW-1:0]  ts_base;
    logic            ts_inc;
    longint unsigned cyc, cyc0;
    logic [TSW-1:0]  timestamp;
    assign timestamp = ts_inc ? (ts_base + TSW'(cyc - cyc0)) : ts_base;

    logic dropped_a, dropped_b;

    frame_stream_packer_if #(.DATA_WIDTH(DW)) s_if ();
    frame_stream_packer_if #(.DATA_WIDTH(DW)) m_if ();
    frame_stream_packer_if #(.DATA_WIDTH(DW)) sb_if ();
    frame_stream_packer_if #(.DATA_WIDTH(DW)) mb_if ();

    frame_stream_packer #(
        .DATA_WIDTH(DW), .MAX_FRAME_BEATS(MAXB),
        .ENABLE_FRAME_LENGTH_HEADER(1), .ENABLE_TIMESTAMP_FOOTER(1),
        .FRAME_LENGTH_WIDTH(FLW), .TIMESTAMP_WIDTH(TSW)
    ) dut (
        .clk(clk), .rst(rst), .timestamp(timestamp),
        .s_axis(s_if), .m_axis(m_if), .frame_dropped(dropped_a)
    );

    frame_stream_packer #(
        .DATA_WIDTH(DW), .MAX_FRAME_BEATS(MAXB),
        .ENABLE_FRAME_LENGTH_HEADER(0), .ENABLE_TIMESTAMP_FOOTER(0),
        .FRAME_LENGTH_WIDTH(FLW), .TIMESTAMP_WIDTH(TSW)
    ) dut_b (
        .clk(clk), .rst(rst), .timestamp(timestamp),
        .s_axis(sb_if), .m_axis(mb_if), .frame_dropped(dropped_b)
    );

    int            n_checks, n_pass;
    beat_t         exp_q[$];
    int            exp_total, out_total, drop_cnt;
    logic [DW-1:0] log_d [4096];
    logic          log_l [4096];
    logic [DW-1:0] pay [2048];
    bit            rand_ready;
    bit            stall_prev;
    logic [DW-1:0] stall_data;
    logic          stall_last;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] logd(input int idx);
        return log_d[idx % 4096];
    endfunction

    function automatic logic logl(input int idx);
        return log_l[idx % 4096];
    endfunction

    // Reference: header = length mod 2^FLW, payload, then timestamp, LS byte first.
    task automatic push_frame(input int len, input logic [TSW-1:0] ts);
        logic [FLW-1:0] l;
        beat_t          b;
        l = FLW'(len);
        for (int k = 0; k < FLW / DW; k++) begin
            b.d = l[k*DW +: DW]; b.l = 1'b0; exp_q.push_back(b); exp_total++;
        end
        for (int i = 0; i < len; i++) begin
            b.d = pay[i]; b.l = 1'b0; exp_q.push_back(b); exp_total++;
        end
        for (int k = 0; k < TSW / DW; k++) begin
            b.d = ts[k*DW +: DW]; b.l = (k == TSW / DW - 1); exp_q.push_back(b); exp_total++;
        end
    endtask

    task automatic send_frame(input int len, input bit gaps, output logic [TSW-1:0] first_ts);
        int waited;
        first_ts = '0;
        @(posedge clk); #1;
        for (int i = 0; i < len; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_if.tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_if.tdata  = pay[i];
            s_if.tlast  = (i == len - 1);
            s_if.tvalid = 1'b1;
            waited = 0;
            @(negedge clk);
            while (!s_if.tready && waited < 20000) begin
                @(negedge clk);
                waited++;
            end
            if (!s_if.tready) begin
                chk("ingress_ready_timeout", 128'(waited), 128'd0);
                s_if.tvalid = 1'b0;
                s_if.tlast  = 1'b0;
                return;
            end
            if (i == 0) first_ts = timestamp;
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        logic [TSW-1:0] fts;
        int             mark, dmark, n, len;

        rst = 1'b1;
        s_if.tvalid = 1'b0;  s_if.tdata = '0;  s_if.tlast = 1'b0;
        sb_if.tvalid = 1'b0; sb_if.tdata = '0; sb_if.tlast = 1'b0;
        m_if.tready = 1'b1;  mb_if.tready = 1'b1;
        ts_base = '0; ts_inc = 1'b0; cyc = 0; cyc0 = 0;
        n_checks = 0; n_pass = 0; exp_total = 0; out_total = 0; drop_cnt = 0;
        rand_ready = 1'b0; stall_prev = 1'b0; stall_data = '0; stall_last = 1'b0;

        fork
            forever @(posedge clk) cyc <= cyc + 1;
            forever begin
                repeat (20) @(posedge clk);
                #1;
                if (rand_ready) m_if.tready = 1'($urandom_range(0, 1));
            end
            forever begin
                @(negedge clk);
                if (m_if.tvalid && m_if.tready) begin
                    log_d[out_total % 4096] = m_if.tdata;
                    log_l[out_total % 4096] = m_if.tlast;
                    out_total++;
                    if (exp_q.size() == 0) begin
                        chk("beat_count", 128'(out_total), 128'(exp_total));
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        chk("beat_data", 128'(m_if.tdata), 128'(e.d));
                        chk("beat_last", 128'(m_if.tlast), 128'(e.l));
                    end
                end
                if (stall_prev) begin
                    chk("stall_valid", 128'(m_if.tvalid), 128'd1);
                    chk("stall_data", 128'(m_if.tdata), 128'(stall_data));
                    chk("stall_last", 128'(m_if.tlast), 128'(stall_last));
                end
                stall_prev = m_if.tvalid && !m_if.tready;
                stall_data = m_if.tdata;
                stall_last = m_if.tlast;
                if (dropped_a) drop_cnt++;
            end
        join_none

        // Values while reset is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 128'(s_if.tready), 128'd0);
        chk("rst_m_tvalid", 128'(m_if.tvalid), 128'd0);
        chk("rst_m_tlast", 128'(m_if.tlast), 128'd0);
        chk("rst_m_tdata", 128'(m_if.tdata), 128'd0);
        chk("rst_dropped", 128'(dropped_a), 128'd0);
        chk("rst_b_tready", 128'(sb_if.tready), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_s_tready", 128'(s_if.tready), 128'd1);

        // Basic 60-beat frame, timestamp held at 0xAB
        ts_base = 72'hAB;
        for (int i = 0; i < 60; i++) pay[i] = 8'(i);
        mark = out_total;
        send_frame(60, 1'b0, fts);
        push_frame(60, fts);
        @(posedge clk);
        @(negedge clk);
        chk("first_beat_latency", 128'(m_if.tvalid), 128'd1);
        wait_drain();
        chk("basic_count", 128'(out_total - mark), 128'd71);
        chk("basic_hdr0", 128'(logd(mark)), 128'h3C);
        chk("basic_hdr1", 128'(logd(mark + 1)), 128'h00);
        chk("basic_pay0", 128'(logd(mark + 2)), 128'h00);
        chk("basic_pay59", 128'(logd(mark + 61)), 128'h3B);
        chk("basic_ts0", 128'(logd(mark + 62)), 128'hAB);
        chk("basic_ts8", 128'(logd(mark + 70)), 128'h00);
        chk("basic_last70", 128'(logl(mark + 70)), 128'd1);
        chk("basic_last69", 128'(logl(mark + 69)), 128'd0);

        // Header/footer disabled instance: single beat 0x5A
        @(posedge clk); #1;
        sb_if.tdata = 8'h5A; sb_if.tlast = 1'b1; sb_if.tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!sb_if.tready && n < 100) begin @(negedge clk); n++; end
        chk("b_ingress_ready", 128'(sb_if.tready), 128'd1);
        @(posedge clk); #1;
        sb_if.tvalid = 1'b0; sb_if.tlast = 1'b0;
        @(negedge clk);
        chk("b_tready_low0", 128'(sb_if.tready), 128'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b_tready_low1", 128'(sb_if.tready), 128'd0);
        chk("b_tvalid", 128'(mb_if.tvalid), 128'd1);
        chk("b_tdata", 128'(mb_if.tdata), 128'h5A);
        chk("b_tlast", 128'(mb_if.tlast), 128'd1);
        @(posedge clk);
        @(negedge clk);
        chk("b_tvalid_after", 128'(mb_if.tvalid), 128'd0);
        chk("b_tready_again", 128'(sb_if.tready), 128'd1);

        // Timestamp sampled at the first beat, not at tlast
        @(negedge clk);
        ts_base = 72'h100; cyc0 = cyc + 1; ts_inc = 1'b1;
        for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
        mark = out_total;
        send_frame(20, 1'b0, fts);
        push_frame(20, fts);
        wait_drain();
        chk("ts_byte0", 128'(logd(mark + 22)), 128'h00);
        chk("ts_byte1", 128'(logd(mark + 23)), 128'h01);
        chk("ts_byte2", 128'(logd(mark + 24)), 128'h00);

        // Maximum legal frame, then an oversize frame, then a 64-beat frame
        for (int i = 0; i < 1601; i++) pay[i] = 8'($urandom);
        mark = out_total;
        send_frame(1600, 1'b0, fts);
        push_frame(1600, fts);
        wait_drain();
        chk("max_count", 128'(out_total - mark), 128'd1611);
        chk("max_hdr0", 128'(logd(mark)), 128'h40);
        chk("max_hdr1", 128'(logd(mark + 1)), 128'h06);
        mark = out_total;
        dmark = drop_cnt;
        send_frame(1601, 1'b0, fts);
        repeat (5) @(posedge clk);
        chk("drop_pulses", 128'(drop_cnt - dmark), 128'd1);
        chk("drop_no_output", 128'(out_total - mark), 128'd0);
        for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
        send_frame(64, 1'b0, fts);
        push_frame(64, fts);
        wait_drain();
        chk("after_drop_count", 128'(out_total - mark), 128'd75);
        chk("drop_total", 128'(drop_cnt - dmark), 128'd1);

        // Random lengths, random ingress gaps, random egress backpressure
        @(negedge clk);
        ts_base = {8'($urandom), $urandom, $urandom}; cyc0 = cyc; ts_inc = 1'b1;
        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 1600))
                                              : int'($urandom_range(1, 64));
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            send_frame(len, 1'b1, fts);
            push_frame(len, fts);
        end
        @(negedge clk);
        rand_ready = 1'b0;
        m_if.tready = 1'b1;
        wait_drain();

        // Reset in the middle of the payload
        for (int i = 0; i < 30; i++) pay[i] = 8'($urandom);
        mark = out_total;
        send_frame(30, 1'b0, fts);
        push_frame(30, fts);
        n = 0;
        while ((out_total - mark) < 10 && n < 5000) begin @(posedge clk); n++; end
        chk("mid_frame_progress", 128'((out_total - mark) >= 10), 128'd1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_total = out_total;
        @(negedge clk);
        chk("rst_mid_tvalid", 128'(m_if.tvalid), 128'd0);
        chk("rst_mid_tlast", 128'(m_if.tlast), 128'd0);
        chk("rst_mid_tdata", 128'(m_if.tdata), 128'd0);
        chk("rst_mid_s_tready", 128'(s_if.tready), 128'd0);
        for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
        mark = out_total;
        send_frame(10, 1'b0, fts);
        push_frame(10, fts);
        wait_drain();
        repeat (20) @(posedge clk);
        chk("post_rst_count", 128'(out_total - mark), 128'd21);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
